// File: rtl/addepadcrc_if.sv
// Byte-stream bundle for the pad/FCS stage: clock-enable, frame enable, valid/data in,
// registered valid/data out towards the preamble inserter.
interface addepadcrc_if;
  logic       i_ce;
  logic       i_en;
  logic       i_v;
  logic [7:0] i_d;
  logic       o_v;
  logic [7:0] o_d;

  modport master (output i_ce, i_en, i_v, i_d, input  o_v, o_d);
  modport slave  (input  i_ce, i_en, i_v, i_d, output o_v, o_d);
endinterface

// File: rtl/addepadcrc.sv
// Ethernet TX stage: zero-pads a raw frame to MIN_LENGTH bytes and appends the
// IEEE 802.3 CRC-32 FCS, one byte per i_ce step with one step of latency.
module addepadcrc #(
  parameter int MIN_LENGTH = 60,
  parameter int LGCNT      = 11
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  addepadcrc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_e;

  localparam logic [31:0] POLY = 32'hEDB88320;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LGCNT-1:0] count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             drop_q, drop_d;
  logic             ov_q, ov_d;
  logic [7:0]       od_q, od_d;

  logic [31:0]      fcs;
  logic [LGCNT-1:0] count_inc;
  logic             short_frame;

  // Reflected CRC-32, LSB of the byte enters first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs         = ~crc_q;
  assign count_inc   = (count_q == '1) ? count_q : count_q + LGCNT'(1);
  assign short_frame = int'(count_q) < MIN_LENGTH;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    count_d = count_q;
    idx_d   = idx_q;
    en_d    = en_q;
    drop_d  = drop_q;
    ov_d    = ov_q;
    od_d    = od_q;

    if (bus.i_ce) begin
      case (state_q)
        IDLE: begin
          crc_d = '1;
          ov_d  = 1'b0;
          od_d  = '0;
          // A dropped frame is ignored until its valid finally goes low here.
          if (!bus.i_v) begin
            drop_d = 1'b0;
          end else if (!drop_q) begin
            ov_d    = 1'b1;
            od_d    = bus.i_d;
            en_d    = bus.i_en;
            crc_d   = crc_byte('1, bus.i_d);
            count_d = LGCNT'(1);
            state_d = DATA;
          end
        end

        DATA: begin
          if (bus.i_v) begin
            ov_d    = 1'b1;
            od_d    = bus.i_d;
            crc_d   = crc_byte(crc_q, bus.i_d);
            count_d = count_inc;
          end else if (!en_q) begin
            ov_d    = 1'b0;
            od_d    = '0;
            state_d = IDLE;
          end else if (short_frame) begin
            ov_d    = 1'b1;
            od_d    = '0;
            crc_d   = crc_byte(crc_q, 8'h00);
            count_d = count_inc;
            state_d = PAD;
          end else begin
            ov_d    = 1'b1;
            od_d    = fcs[7:0];
            idx_d   = 2'd1;
            state_d = FCS;
          end
        end

        PAD: begin
          drop_d = drop_q | bus.i_v;
          ov_d   = 1'b1;
          if (short_frame) begin
            od_d    = '0;
            crc_d   = crc_byte(crc_q, 8'h00);
            count_d = count_inc;
          end else begin
            od_d    = fcs[7:0];
            idx_d   = 2'd1;
            state_d = FCS;
          end
        end

        FCS: begin
          drop_d = drop_q | bus.i_v;
          ov_d   = 1'b1;
          od_d   = fcs[{idx_q, 3'b000} +: 8];
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      crc_q   <= '1;
      count_q <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      drop_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign bus.o_v = ov_q;
  assign bus.o_d = od_q;

endmodule

// File: tb/tb_addepadcrc.sv
// Bench for addepadcrc: three instances (no padding, 60-byte minimum, 12-byte minimum
// with a 4-bit counter) driven by one stream and compared against a frame-level model.
module tb_addepadcrc;

  localparam int MAXS = 200;
  localparam int MINS [3] = '{0, 60, 12};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce    = 1'b0;
  logic       en    = 1'b0;
  logic       v     = 1'b0;
  logic [7:0] d     = 8'h00;

  int checks = 0;
  int errors = 0;

  addepadcrc_if b0 ();
  addepadcrc_if b60 ();
  addepadcrc_if bs ();

  assign b0.i_ce  = ce;  assign b0.i_en  = en;  assign b0.i_v  = v;  assign b0.i_d  = d;
  assign b60.i_ce = ce;  assign b60.i_en = en;  assign b60.i_v = v;  assign b60.i_d = d;
  assign bs.i_ce  = ce;  assign bs.i_en  = en;  assign bs.i_v  = v;  assign bs.i_d  = d;

  addepadcrc #(.MIN_LENGTH(0),  .LGCNT(11)) dut0  (.i_clk(clk), .i_reset_n(rst_n), .bus(b0));
  addepadcrc #(.MIN_LENGTH(60), .LGCNT(11)) dut60 (.i_clk(clk), .i_reset_n(rst_n), .bus(b60));
  addepadcrc #(.MIN_LENGTH(12), .LGCNT(4))  duts  (.i_clk(clk), .i_reset_n(rst_n), .bus(bs));

  always #5 clk = ~clk;

  // Output capture: one entry per i_ce step, sampled on the falling edge.
  logic [8:0] o0, o60, os;
  assign o0  = {b0.o_v,  b0.o_d};
  assign o60 = {b60.o_v, b60.o_d};
  assign os  = {bs.o_v,  bs.o_d};

  logic       ce_at_edge = 1'b0;
  logic       stab_on    = 1'b0;
  logic [8:0] last0 = '0, last60 = '0, lasts = '0;
  logic [8:0] cap0[$], cap60[$], caps[$];

  always @(posedge clk) ce_at_edge <= ce;

  task automatic hold_check(input int k, input logic [8:0] now, input logic [8:0] prev);
    checks++;
    assert (now === prev) else begin
      errors++;
      $error("FAIL hold_min%0d: got %h want %h", MINS[k], now, prev);
    end
  endtask

  always @(negedge clk) begin
    if (ce_at_edge) begin
      cap0.push_back(o0);
      cap60.push_back(o60);
      caps.push_back(os);
    end else if (stab_on) begin
      hold_check(0, o0, last0);
      hold_check(1, o60, last60);
      hold_check(2, os, lasts);
    end
    last0  = o0;
    last60 = o60;
    lasts  = os;
  end

  // Stimulus plan and expected output per step, per instance.
  logic       stim_v  [MAXS];
  logic [7:0] stim_d  [MAXS];
  logic       stim_en [MAXS];
  logic       exp_v   [3][MAXS];
  logic [7:0] exp_d   [3][MAXS];
  logic [7:0] fb[$];

  function automatic logic [31:0] crc_reg(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fbit;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fbit = c[0] ^ q[i][b];
        c    = {1'b0, c[31:1]} ^ (fbit ? 32'hEDB88320 : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic clear_plan();
    for (int s = 0; s < MAXS; s++) begin
      stim_v[s] = 1'b0; stim_d[s] = 8'h00; stim_en[s] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_v[k][s] = 1'b0;
        exp_d[k][s] = 8'h00;
      end
    end
    fb.delete();
  endtask

  task automatic place(input int k, input int start, input logic en0, input logic [7:0] src[$]);
    logic [7:0]  ef[$];
    logic [31:0] c;
    ef = src;
    if (en0) begin
      while (ef.size() < MINS[k]) ef.push_back(8'h00);
      c = ~crc_reg(ef);
      for (int j = 0; j < 4; j++) ef.push_back(c[8*j +: 8]);
    end
    foreach (ef[j]) begin
      exp_v[k][start+j] = 1'b1;
      exp_d[k][start+j] = ef[j];
    end
  endtask

  task automatic add_frame(input int start, input logic en0, input bit en_noise, input bit dropped);
    foreach (fb[i]) begin
      stim_v[start+i]  = 1'b1;
      stim_d[start+i]  = fb[i];
      stim_en[start+i] = (i == 0 || !en_noise) ? en0 : 1'($urandom_range(0, 1));
    end
    if (!dropped) begin
      for (int k = 0; k < 3; k++) place(k, start, en0, fb);
    end
    fb.delete();
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  task automatic step(input bit rand_ce);
    if (rand_ce) begin
      while ($urandom_range(0, 99) < 60) begin
        ce = 1'b0;
        @(posedge clk); #1;
      end
    end
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic compare(input int k, input int n, input logic [8:0] cap[$]);
    checks++;
    assert (cap.size() == n) else begin
      errors++;
      $error("FAIL steps_min%0d: got %0d want %0d", MINS[k], cap.size(), n);
    end
    for (int s = 0; s < n && s < cap.size(); s++) begin
      checks++;
      assert (cap[s][8] === exp_v[k][s]) else begin
        errors++;
        $error("FAIL ov_min%0d step %0d: got %b want %b", MINS[k], s, cap[s][8], exp_v[k][s]);
      end
      if (exp_v[k][s]) begin
        checks++;
        assert (cap[s][7:0] === exp_d[k][s]) else begin
          errors++;
          $error("FAIL od_min%0d step %0d: got %h want %h", MINS[k], s, cap[s][7:0], exp_d[k][s]);
        end
      end
    end
  endtask

  task automatic run_episode(input int n, input bit rand_ce);
    cap0.delete(); cap60.delete(); caps.delete();
    stab_on = rand_ce;
    for (int s = 0; s < n; s++) begin
      v = stim_v[s]; d = stim_d[s]; en = stim_en[s];
      step(rand_ce);
    end
    v = 1'b0; d = 8'h00; en = 1'b0;
    @(negedge clk); #1;
    stab_on = 1'b0;
    compare(0, n, cap0);
    compare(1, n, cap60);
    compare(2, n, caps);
  endtask

  task automatic residue_check(input string tag, input logic [8:0] cap[$]);
    logic [7:0]  q[$];
    logic [31:0] r, rr;
    foreach (cap[s]) if (cap[s][8]) q.push_back(cap[s][7:0]);
    r  = crc_reg(q);
    rr = {<<{r}};
    checks++;
    assert (rr === 32'hC704DD7B) else begin
      errors++;
      $error("FAIL residue_%s: got %h want c704dd7b", tag, rr);
    end
  endtask

  task automatic reset_check(input string tag);
    checks += 2;
    assert (o0 === 9'h000 && o60 === 9'h000) else begin
      errors++;
      $error("FAIL %s_a: got %h/%h want 000/000", tag, o0, o60);
    end
    assert (os === 9'h000) else begin
      errors++;
      $error("FAIL %s_b: got %h want 000", tag, os);
    end
  endtask

  logic [7:0] lit [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // "123456789" through all instances; the unpadded one must end in 26 39 F4 CB.
    clear_plan();
    for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_episode(75, 1'b0);
    for (int j = 0; j < 4; j++) begin
      checks++;
      assert (cap0.size() > 12 && cap0[9+j][7:0] === lit[j]) else begin
        errors++;
        $error("FAIL check_fcs byte %0d: got %h want %h", j, (cap0.size() > 12) ? cap0[9+j][7:0] : 8'hxx, lit[j]);
      end
    end

    // Single byte: 1 data + 59 pad + FCS on the 60-byte instance.
    clear_plan();
    fb.push_back(8'hAA);
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_episode(70, 1'b0);
    residue_check("min60", cap60);
    residue_check("min0", cap0);

    // Pass-through with enable low.
    clear_plan();
    rand_bytes(10);
    add_frame(0, 1'b0, 1'b0, 1'b0);
    run_episode(14, 1'b0);

    // Exactly-minimum and one-over-minimum frames, plus a frame past the small counter's range.
    for (int len = 60; len <= 61; len++) begin
      clear_plan();
      rand_bytes(len);
      add_frame(0, 1'b1, 1'b0, 1'b0);
      run_episode(70, 1'b0);
    end
    clear_plan();
    rand_bytes(20);
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_episode(70, 1'b0);

    // "123456789" with random i_ce gaps.
    clear_plan();
    for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_episode(75, 1'b1);

    // Random frames, random enable, enable noise after the first byte.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 90);
      clear_plan();
      rand_bytes(len);
      add_frame(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      run_episode(len + 70, r[0]);
    end

    // Overlap: frame B arrives during A's pad/FCS and must vanish; C is clean.
    clear_plan();
    rand_bytes(3);
    add_frame(0, 1'b1, 1'b0, 1'b0);
    rand_bytes(4);
    add_frame(4, 1'b1, 1'b0, 1'b1);
    rand_bytes(5);
    add_frame(75, 1'b1, 1'b0, 1'b0);
    run_episode(145, 1'b0);

    // Asynchronous reset mid-payload, then the stream continues as a new frame.
    clear_plan();
    v = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      step(1'b0);
    end
    #2 rst_n = 1'b0;
    #1 reset_check("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    rand_bytes(3);
    add_frame(0, 1'b1, 1'b0, 1'b0);
    run_episode(70, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
